// File: rtl/trig_sequencer_if.sv
// Handshake and status bundle between the trigger sequencer and its controller.
interface trig_sequencer_if;
  logic        HW_TRG_REQ;
  logic        TRG_SOFT;
  logic [11:0] TRG_MASK;
  logic [11:0] ACK;
  logic        CLR_STATS;
  logic [11:0] TRG;
  logic        BUSY;
  logic [31:0] TRG_COUNT;
  logic [15:0] LOST_COUNT;
  logic [15:0] TIMEOUT_COUNT;
  logic [11:0] MISSING_ACK;

  modport master (
    output HW_TRG_REQ, TRG_SOFT, TRG_MASK, ACK, CLR_STATS,
    input  TRG, BUSY, TRG_COUNT, LOST_COUNT, TIMEOUT_COUNT, MISSING_ACK
  );

  modport slave (
    input  HW_TRG_REQ, TRG_SOFT, TRG_MASK, ACK, CLR_STATS,
    output TRG, BUSY, TRG_COUNT, LOST_COUNT, TIMEOUT_COUNT, MISSING_ACK
  );
endinterface

// File: rtl/trig_sequencer.sv
// Trigger fan-out sequencer: fire, collect per-SCROD ACK, wait release, hold off, keep stats.
// Define TRIG_SEQ_ACK_TIMEOUT_EN to build the WAIT_ACK timeout and its statistics.
module trig_sequencer #(
  parameter int unsigned TRG_WIDTH   = 4,
  parameter int unsigned HOLDOFF     = 8,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input logic             CLK_80MHZ,
  input logic             RESET,
  trig_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StFire, StWaitAck, StWaitRelease, StHoldoff} state_e;

  state_e      state_q, state_d;
  logic [11:0] mask_q, mask_d;
  logic [11:0] ack_seen_q, ack_seen_d;
  logic [11:0] trg_q, trg_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] trg_count_q, trg_count_d;
  logic [15:0] lost_q, lost_d;
  logic        soft_q, hw_q;

  logic        soft_rise, hw_rise, start, full_ack, fire_done, hold_done, timeout;
  logic [11:0] ack_m;

  assign soft_rise = bus.TRG_SOFT & ~soft_q;
  assign hw_rise   = bus.HW_TRG_REQ & ~hw_q;
  assign start     = (state_q == StIdle) && (bus.HW_TRG_REQ || soft_rise) && (bus.TRG_MASK != '0);
  assign ack_m     = bus.ACK & mask_q;
  assign full_ack  = ((ack_seen_q | bus.ACK) & mask_q) == mask_q;
  assign fire_done = cnt_q == 8'(TRG_WIDTH - 1);
  // HOLDOFF=0 still spends one cycle in the state, hence the +1 form
  assign hold_done = ({1'b0, cnt_q} + 9'd1) >= 9'(HOLDOFF);

  always_ff @(posedge CLK_80MHZ) begin
    if (!RESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:        if (start) state_d = StFire;
      StFire:        if (fire_done) state_d = StWaitAck;
      StWaitAck: begin
        if (full_ack)     state_d = StWaitRelease;
        else if (timeout) state_d = StHoldoff;
      end
      StWaitRelease: if (ack_m == '0) state_d = StHoldoff;
      StHoldoff:     if (hold_done) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.BUSY       = (state_q != StIdle);
    bus.TRG        = trg_q;
    bus.TRG_COUNT  = trg_count_q;
    bus.LOST_COUNT = lost_q;
  end

  always_comb begin
    mask_d     = start ? bus.TRG_MASK : mask_q;
    ack_seen_d = ack_seen_q;
    if (state_q == StFire && fire_done) ack_seen_d = '0;
    else if (state_q == StWaitAck)      ack_seen_d = ack_seen_q | ack_m;
    if (state_d == state_q && (state_q == StFire || state_q == StHoldoff)) cnt_d = cnt_q + 8'd1;
    else                                                                    cnt_d = '0;
    // One register stage after the state so TRG starts the edge after the request is taken
    trg_d = (state_q == StFire) ? mask_q : '0;
    trg_count_d = trg_count_q;
    if (bus.CLR_STATS) trg_count_d = '0;
    else if (start)    trg_count_d = trg_count_q + 32'd1;
    lost_d = lost_q;
    if (bus.CLR_STATS) lost_d = '0;
    else if (state_q != StIdle && (hw_rise || soft_rise) && lost_q != 16'hFFFF)
      lost_d = lost_q + 16'd1;
  end

  always_ff @(posedge CLK_80MHZ) begin
    if (!RESET) begin
      mask_q      <= '0;
      ack_seen_q  <= '0;
      trg_q       <= '0;
      cnt_q       <= '0;
      trg_count_q <= '0;
      lost_q      <= '0;
      soft_q      <= 1'b0;
      hw_q        <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      ack_seen_q  <= ack_seen_d;
      trg_q       <= trg_d;
      cnt_q       <= cnt_d;
      trg_count_q <= trg_count_d;
      lost_q      <= lost_d;
      soft_q      <= bus.TRG_SOFT;
      hw_q        <= bus.HW_TRG_REQ;
    end
  end

`ifdef TRIG_SEQ_ACK_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [11:0] miss_q, miss_d;

  always_comb begin
    timeout  = (state_q == StWaitAck) && !full_ack && (to_cnt_q == 16'(ACK_TIMEOUT - 1));
    to_cnt_d = (state_q == StWaitAck) ? to_cnt_q + 16'd1 : '0;
    tmo_d    = tmo_q;
    miss_d   = miss_q;
    if (bus.CLR_STATS) begin
      tmo_d  = '0;
      miss_d = '0;
    end else if (timeout) begin
      miss_d = miss_q | (mask_q & ~(ack_seen_q | bus.ACK));
      if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge CLK_80MHZ) begin
    if (!RESET) begin
      to_cnt_q <= '0;
      tmo_q    <= '0;
      miss_q   <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
      tmo_q    <= tmo_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.TIMEOUT_COUNT = tmo_q;
  assign bus.MISSING_ACK   = miss_q;
`else
  assign timeout           = 1'b0;
  assign bus.TIMEOUT_COUNT = '0;
  assign bus.MISSING_ACK   = '0;
`endif

endmodule

// File: tb/tb_trig_sequencer.sv
// Scoreboard bench for trig_sequencer: stimulus pushes expected triggers/status, a monitor checks.
module tb_trig_sequencer;
  localparam int unsigned TrgWidth = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #6 clk = ~clk;

  trig_sequencer_if bus ();

  trig_sequencer #(
    .TRG_WIDTH  (TrgWidth),
    .HOLDOFF    (8),
    .ACK_TIMEOUT(20)
  ) dut (
    .CLK_80MHZ(clk),
    .RESET    (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [11:0] mask;
    int          rise;
    int          width;
  } trig_exp_t;

  typedef struct {
    string       name;
    logic [31:0] cnt;
    logic [15:0] lost;
    logic [15:0] tmo;
    logic [11:0] miss;
    logic        busy;
    logic        chk_trg;
  } stat_exp_t;

  trig_exp_t trig_q[$];
  stat_exp_t stat_q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit          mon_active;
  int          mon_width;
  int          mon_wexp;
  logic [11:0] mon_cur;
  trig_exp_t   te;
  stat_exp_t   se;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  initial begin
    mon_active = 0;
    mon_width  = 0;
    mon_wexp   = TrgWidth;
    mon_cur    = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.TRG != '0 && !mon_active) begin
        mon_active = 1;
        mon_width  = 1;
        mon_cur    = bus.TRG;
        if (trig_q.size() == 0) begin
          mon_wexp = TrgWidth;
          chk("spurious_trg", bus.TRG, 32'd0);
        end else begin
          te       = trig_q.pop_front();
          mon_wexp = te.width;
          chk("trg_mask", bus.TRG, te.mask);
          chk("trg_rise_cycle", cyc, te.rise);
        end
      end else if (mon_active && bus.TRG != '0) begin
        mon_width++;
        if (bus.TRG != mon_cur) chk("trg_stable", bus.TRG, mon_cur);
      end else if (mon_active) begin
        mon_active = 0;
        chk("trg_width", mon_width, mon_wexp);
      end
      if (stat_q.size() != 0) begin
        se = stat_q.pop_front();
        chk({se.name, ".trg_count"}, bus.TRG_COUNT, se.cnt);
        chk({se.name, ".lost_count"}, bus.LOST_COUNT, se.lost);
        chk({se.name, ".timeout_count"}, bus.TIMEOUT_COUNT, se.tmo);
        chk({se.name, ".missing_ack"}, bus.MISSING_ACK, se.miss);
        chk({se.name, ".busy"}, bus.BUSY, se.busy);
        if (se.chk_trg) chk({se.name, ".trg"}, bus.TRG, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Request being driven now is sampled at edge cyc+1, so TRG must first show after cyc+2
  task automatic exp_trig(input logic [11:0] m, input int w);
    trig_q.push_back('{mask: m, rise: cyc + 2, width: w});
  endtask

  task automatic exp_stat(input string nm, input logic [31:0] c, input logic [15:0] l,
                          input logic b, input logic [15:0] t, input logic [11:0] ms,
                          input logic ct);
    stat_q.push_back('{name: nm, cnt: c, lost: l, tmo: t, miss: ms, busy: b, chk_trg: ct});
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.BUSY !== 1'b0 && n < 200) begin
      step(1);
      n++;
    end
    if (bus.BUSY !== 1'b0) chk({nm, ".idle_wait_expired"}, bus.BUSY, 32'd0);
  endtask

  // Called one cycle after the request edge; ACK rises 10 cycles after it and falls 5 later
  task automatic handshake(input logic [11:0] ackv, input string nm);
    step(9);
    bus.ACK = ackv;
    step(5);
    bus.ACK = '0;
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    bus.HW_TRG_REQ = 1'b0;
    bus.TRG_SOFT   = 1'b0;
    bus.TRG_MASK   = '0;
    bus.ACK        = '0;
    bus.CLR_STATS  = 1'b0;

    // Reset state
    step(1);
    exp_stat("reset", 0, 0, 0, 0, 0, 1);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Basic trigger with full mask and handshake
    bus.TRG_MASK   = 12'hFFF;
    bus.HW_TRG_REQ = 1'b1;
    exp_trig(12'hFFF, TrgWidth);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    step(9);
    bus.ACK = 12'hFFF;
    step(5);
    bus.ACK = '0;
    step(7);
    exp_stat("basic_holdoff", 1, 0, 1, 0, 0, 0);
    step(1);
    exp_stat("basic_idle", 1, 0, 0, 0, 0, 0);
    step(1);

    // Three soft edges while busy, then a coincident hw+soft request in IDLE
    bus.TRG_MASK   = 12'h00F;
    bus.HW_TRG_REQ = 1'b1;
    exp_trig(12'h00F, TrgWidth);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    step(2);
    for (int i = 0; i < 3; i++) begin
      bus.TRG_SOFT = 1'b1;
      step(1);
      bus.TRG_SOFT = 1'b0;
      step(1);
    end
    step(1);
    bus.ACK = 12'h00F;
    step(5);
    exp_stat("lost_three", 2, 3, 1, 0, 0, 0);
    bus.ACK = '0;
    wait_idle("lost_three");
    bus.HW_TRG_REQ = 1'b1;
    bus.TRG_SOFT   = 1'b1;
    exp_trig(12'h00F, TrgWidth);
    exp_stat("coincident", 3, 3, 1, 0, 0, 0);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    bus.TRG_SOFT   = 1'b0;
    handshake(12'h00F, "coincident");

    // Mask changed during FIRE: TRG and ACK checking use the snapshot
    bus.TRG_MASK   = 12'h0F0;
    bus.HW_TRG_REQ = 1'b1;
    exp_trig(12'h0F0, TrgWidth);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    bus.TRG_MASK   = 12'hF00;
    step(4);
    bus.ACK = 12'hF00;
    step(3);
    bus.ACK = 12'h0F0;
    step(1);
    bus.ACK = 12'hF00;
    step(7);
    exp_stat("mask_snap_busy", 4, 3, 1, 0, 0, 0);
    step(1);
    exp_stat("mask_snap_idle", 4, 3, 0, 0, 0, 0);
    step(1);
    bus.ACK = '0;

    // Reset during WAIT_ACK, then a zero-mask request after release
    bus.TRG_MASK   = 12'h003;
    bus.HW_TRG_REQ = 1'b1;
    exp_trig(12'h003, TrgWidth);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    step(5);
    exp_stat("pre_reset", 5, 3, 1, 0, 0, 0);
    step(1);
    rst_n          = 1'b0;
    bus.HW_TRG_REQ = 1'b1;
    bus.TRG_MASK   = '0;
    exp_stat("reset_wait_ack", 0, 0, 0, 0, 0, 1);
    step(1);
    rst_n = 1'b1;
    step(3);
    exp_stat("zero_mask", 0, 0, 0, 0, 0, 0);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    step(1);

    // Soft level held across reset release counts as one edge; reset then aborts FIRE
    rst_n        = 1'b0;
    bus.TRG_SOFT = 1'b1;
    bus.TRG_MASK = 12'h001;
    step(2);
    rst_n = 1'b1;
    exp_trig(12'h001, 2);
    step(2);
    exp_stat("soft_across_reset", 1, 0, 1, 0, 0, 0);
    step(1);
    rst_n        = 1'b0;
    bus.TRG_SOFT = 1'b0;
    exp_stat("abort_fire", 0, 0, 0, 0, 0, 1);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Held request re-triggers on return to IDLE
    bus.TRG_MASK   = 12'h010;
    bus.HW_TRG_REQ = 1'b1;
    exp_trig(12'h010, TrgWidth);
    step(10);
    bus.ACK = 12'h010;
    step(5);
    bus.ACK = '0;
    step(9);
    exp_trig(12'h010, TrgWidth);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    handshake(12'h010, "retrigger");
    exp_stat("retrigger", 2, 0, 0, 0, 0, 0);
    step(1);

    // Count wraps from all-ones; CLR_STATS wins over a same-cycle trigger
    force dut.trg_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.trg_count_q;
    bus.TRG_MASK   = 12'h001;
    bus.HW_TRG_REQ = 1'b1;
    exp_trig(12'h001, TrgWidth);
    exp_stat("count_wrap", 0, 0, 1, 0, 0, 0);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    handshake(12'h001, "count_wrap");
    bus.TRG_MASK   = 12'h002;
    bus.HW_TRG_REQ = 1'b1;
    bus.CLR_STATS  = 1'b1;
    exp_trig(12'h002, TrgWidth);
    exp_stat("clr_vs_trigger", 0, 0, 1, 0, 0, 0);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    bus.CLR_STATS  = 1'b0;
    handshake(12'h002, "clr_vs_trigger");
    exp_stat("clr_end", 0, 0, 0, 0, 0, 0);
    step(1);

`ifdef TRIG_SEQ_ACK_TIMEOUT_EN
    // Partial ACK times out 20 cycles into WAIT_ACK
    bus.TRG_MASK   = 12'h00F;
    bus.ACK        = 12'h007;
    bus.HW_TRG_REQ = 1'b1;
    exp_trig(12'h00F, TrgWidth);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    step(22);
    exp_stat("pre_timeout", 1, 0, 1, 0, 0, 0);
    step(1);
    exp_stat("timeout", 1, 0, 1, 1, 12'h008, 0);
    step(7);
    exp_stat("timeout_holdoff", 1, 0, 1, 1, 12'h008, 0);
    step(1);
    exp_stat("timeout_idle", 1, 0, 0, 1, 12'h008, 0);
    step(1);
    bus.ACK       = '0;
    bus.CLR_STATS = 1'b1;
    exp_stat("timeout_clr", 0, 0, 0, 0, 0, 0);
    step(1);
    bus.CLR_STATS = 1'b0;
`else
    // Without the timeout build a partial ACK waits indefinitely
    bus.TRG_MASK   = 12'h00F;
    bus.ACK        = 12'h007;
    bus.HW_TRG_REQ = 1'b1;
    exp_trig(12'h00F, TrgWidth);
    step(1);
    bus.HW_TRG_REQ = 1'b0;
    step(30);
    exp_stat("no_timeout", 1, 0, 1, 0, 0, 0);
    step(1);
    bus.ACK = 12'h00F;
    step(1);
    bus.ACK = '0;
    wait_idle("no_timeout");
`endif

    step(3);
    chk("pending_trg", trig_q.size(), 32'd0);
    chk("pending_stat", stat_q.size(), 32'd0);
    chk("trg_end", bus.TRG, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trig_sequencer.md
TRIG_SEQUENCER -- requirements
Module: trig_sequencer

Interface
REQ-001 Parameter TRG_WIDTH, default 4: number of cycles TRG is held high per trigger; legal range 1..255.
REQ-002 Parameter HOLDOFF, default 8: number of dead cycles after each trigger cycle before re-arm; legal range 0..255.
REQ-003 Parameter ACK_TIMEOUT, default 1023: maximum number of cycles spent in WAIT_ACK; legal range 1..65535.
REQ-004 CLK_80MHZ  in  1  sole clock; all logic on posedge.
REQ-005 RESET  in  1  synchronous, active-low reset (0 = reset).
REQ-006 HW_TRG_REQ  in  1  level coincidence request from the multiplicity logic.
REQ-007 TRG_SOFT  in  1  software trigger; only its rising edge acts.
REQ-008 TRG_MASK  in  12  per-SCROD enable.
REQ-009 ACK  in  12  per-SCROD acknowledge/busy.
REQ-010 CLR_STATS  in  1  synchronous clear of all statistics.
REQ-011 TRG  out  12  registered trigger fan-out to the SCRODs.
REQ-012 BUSY  out  1  high whenever the state is not IDLE.
REQ-013 TRG_COUNT  out  32  number of issued triggers.
REQ-014 LOST_COUNT  out  16  number of requests dropped while BUSY.
REQ-015 TIMEOUT_COUNT  out  16  number of ACK timeouts.
REQ-016 MISSING_ACK  out  12  per-SCROD sticky flags for SCRODs that failed to acknowledge.

Function
REQ-017 The block SHALL implement five states: IDLE, FIRE, WAIT_ACK, WAIT_RELEASE, HOLDOFF.
REQ-018 IDLE: when (HW_TRG_REQ=1 or a TRG_SOFT rising edge) and TRG_MASK!=0, the block SHALL snapshot TRG_MASK into mask_q, increment TRG_COUNT (wrapping modulo 2^32) and enter FIRE.
REQ-019 A request sampled at edge N SHALL drive TRG=mask_q from edge N+1 through edge N+TRG_WIDTH, and TRG SHALL be 0 otherwise.
REQ-020 A simultaneous hardware and soft request SHALL produce one trigger and one TRG_COUNT increment.
REQ-021 In IDLE, a request with TRG_MASK=0 SHALL be ignored and SHALL NOT be counted in either TRG_COUNT or LOST_COUNT.
REQ-022 FIRE: after TRG_WIDTH cycles the block SHALL enter WAIT_ACK and clear the acknowledge accumulator ack_seen.
REQ-023 WAIT_ACK: ack_seen SHALL accumulate ACK&mask_q.
- When (ack_seen|ACK)&mask_q equals mask_q, the block SHALL enter WAIT_RELEASE.
REQ-024 WAIT_RELEASE: once ACK&mask_q is 0, the block SHALL enter HOLDOFF.
REQ-025 HOLDOFF: after HOLDOFF cycles the block SHALL return to IDLE; HOLDOFF=0 SHALL return to IDLE on the next edge.
REQ-026 A HW_TRG_REQ rising edge or a TRG_SOFT rising edge occurring outside IDLE SHALL increment LOST_COUNT, saturating at 0xFFFF; the two edges coinciding SHALL count as one.
REQ-027 Changes to TRG_MASK after the snapshot SHALL NOT affect the trigger cycle in progress.
REQ-028 A request held continuously high SHALL re-trigger on each return to IDLE.
REQ-029 CLR_STATS=1 SHALL zero TRG_COUNT, LOST_COUNT, TIMEOUT_COUNT and MISSING_ACK on the next edge.
- CLR_STATS SHALL have priority over a same-cycle increment.
- CLR_STATS SHALL NOT change the current state.

Reset
REQ-030 While RESET=0 at a posedge, the block SHALL go to IDLE with TRG=0, BUSY=0, all counters 0, MISSING_ACK=0, mask_q=0 and ack_seen=0.
REQ-031 Reset asserted mid-cycle (in any state) SHALL abort the cycle, and TRG SHALL be 0 on the following edge.
REQ-032 The TRG_SOFT edge detector SHALL be re-initialised to 0 by reset.
- A TRG_SOFT level held high across reset release SHALL therefore count as one edge.

Configuration
REQ-033 With macro TRIG_SEQ_ACK_TIMEOUT_EN defined, WAIT_ACK SHALL count cycles and perform the timeout action once ACK_TIMEOUT cycles elapse without full acknowledge.
- Timeout action: MISSING_ACK |= mask_q & ~ack_seen_final, where ack_seen_final = ack_seen|ACK in that cycle.
- Timeout action: TIMEOUT_COUNT increments, saturating at 0xFFFF.
- Timeout action: the block SHALL enter HOLDOFF, skipping WAIT_RELEASE.
REQ-034 Without the macro, WAIT_ACK SHALL wait indefinitely.
- TIMEOUT_COUNT and MISSING_ACK SHALL be constant 0.
- No timeout counter logic SHALL be synthesised.

Verification
REQ-035 Defaults, TRG_MASK=0xFFF, HW_TRG_REQ pulsed for 1 cycle, ACK all rising 10 cycles later and falling 5 cycles after that:
- TRG=0xFFF for exactly 4 cycles starting 1 cycle after the request.
- TRG_COUNT=1.
- BUSY returns to 0 8 cycles after ACK falls.
REQ-036 Macro on, ACK_TIMEOUT=20, TRG_MASK=0x00F, ACK=0x007 held:
- TIMEOUT_COUNT=1 and MISSING_ACK=0x008.
- The block enters HOLDOFF 20 cycles after entering WAIT_ACK.
REQ-037 Three TRG_SOFT edges while BUSY, plus one TRG_SOFT edge in the same cycle as a HW_TRG_REQ rising edge in IDLE:
- LOST_COUNT=3.
- TRG_COUNT increments by 1 for the coincident pair.
REQ-038 TRG_MASK changed from 0x0F0 to 0xF00 during FIRE: TRG stays 0x0F0, and WAIT_ACK checks only ACK[7:4].
REQ-039 RESET=0 asserted during WAIT_ACK with TRG_COUNT=5:
- Next edge: state IDLE, TRG_COUNT=0, BUSY=0.
- After release, TRG_MASK=0 with HW_TRG_REQ=1 yields no trigger.
REQ-040 TRG_COUNT preloaded to 0xFFFFFFFF (force) followed by one trigger yields TRG_COUNT=0; CLR_STATS asserted in the same cycle as a trigger yields TRG_COUNT=0.
